// File: rtl/elbeth_fetch_control_if.sv
// Instruction-memory request bus used by the Elbeth fetch sequencer.
//
// Signals:
//   imem_req    fetch request, held with a stable address until acknowledged
//   imem_addr   word-aligned fetch address
//   imem_ack    response valid; may arrive in the same cycle as the request
//   imem_rdata  instruction word, meaningful only while imem_ack is high
//
// Modports:
//   master  the fetch sequencer (drives the request)
//   slave   the instruction memory (drives the response)
interface elbeth_fetch_control_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/elbeth_fetch_control.sv
// Instruction-fetch sequencer for the Elbeth RV32 core.
//
// Owns the program counter and runs the valid/ack handshake to instruction
// memory. Loads the IF/ID pipeline register, redirects fetch on taken
// branches from the ID stage, absorbs ID-stage stalls with a one-word hold
// buffer and throws away fetches that a redirect has made stale.
//
// Ports:
//   clk, rst_n      core clock, asynchronous active-low reset
//   id_valid        ID stage holds a valid instruction
//   id_stall        hazard stall, IF/ID register must hold
//   branch_taken    branch unit requests a redirect
//   pc_branch       redirect target (low two bits ignored)
//   imem            instruction-memory bus (master side)
//   if_valid        IF/ID register holds a valid instruction
//   if_pc           PC of the IF/ID instruction
//   if_instruction  IF/ID instruction word
//   if_flush        one-cycle pulse when a redirect squashes the younger fetch
module elbeth_fetch_control #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          id_valid,
    input  logic                          id_stall,
    input  logic                          branch_taken,
    input  logic [31:0]                   pc_branch,
    elbeth_fetch_control_if.master        imem,
    output logic                          if_valid,
    output logic [31:0]                   if_pc,
    output logic [31:0]                   if_instruction,
    output logic                          if_flush
);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        KILL,
        HOLD
    } fetch_state_t;

    fetch_state_t state, state_next;

    logic [31:0] pc_reg, pc_next;
    logic [31:0] redirect_pc, redirect_pc_next;
    logic [31:0] hold_pc, hold_instr;
    logic        hold_load;
    logic        ifid_load;
    logic [31:0] ifid_pc_d, ifid_instr_d;
    logic        req;
    logic        redirect;
    logic [31:0] target;

    // A redirect is only honoured when ID is not stalled, so it can never
    // coincide with a held IF/ID register.
    assign redirect = id_valid & branch_taken & ~id_stall;
    assign target   = pc_branch & 32'hFFFF_FFFC;

    // The flush pulse is gated by reset so every output sits at its reset
    // value while rst_n is low, whatever the ID stage is driving.
    assign if_flush = redirect & rst_n;

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_reg;

    // Next-state and datapath-control decode. In FETCH the rules are
    // prioritised: a redirect beats a stall, a stall beats a normal
    // delivery. KILL keeps the stale request on the bus until memory
    // answers, then jumps to the latest latched target.
    always_comb begin
        state_next       = state;
        pc_next          = pc_reg;
        redirect_pc_next = redirect_pc;
        hold_load        = 1'b0;
        ifid_load        = 1'b0;
        ifid_pc_d        = pc_reg;
        ifid_instr_d     = imem.imem_rdata;
        req              = 1'b0;

        case (state)
            BOOT: begin
                state_next = FETCH;
            end

            FETCH: begin
                req = 1'b1;
                if (imem.imem_ack && redirect) begin
                    pc_next = target;
                end else if (imem.imem_ack && id_stall) begin
                    hold_load  = 1'b1;
                    pc_next    = pc_reg + 32'd4;
                    state_next = HOLD;
                end else if (imem.imem_ack) begin
                    ifid_load = 1'b1;
                    pc_next   = pc_reg + 32'd4;
                end else if (redirect) begin
                    redirect_pc_next = target;
                    state_next       = KILL;
                end
            end

            KILL: begin
                req = 1'b1;
                if (redirect) begin
                    redirect_pc_next = target;
                end
                if (imem.imem_ack) begin
                    pc_next    = redirect ? target : redirect_pc;
                    state_next = FETCH;
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_next    = target;
                    state_next = FETCH;
                end else if (!id_stall) begin
                    ifid_load    = 1'b1;
                    ifid_pc_d    = hold_pc;
                    ifid_instr_d = hold_instr;
                    state_next   = FETCH;
                end
            end

            default: begin
                state_next = BOOT;
            end
        endcase
    end

    // Sequencer state, program counter, pending redirect target and the
    // one-word hold buffer used while ID is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc_reg      <= RESET_PC;
            redirect_pc <= RESET_PC;
            hold_pc     <= 32'd0;
            hold_instr  <= 32'd0;
        end else begin
            state       <= state_next;
            pc_reg      <= pc_next;
            redirect_pc <= redirect_pc_next;
            if (hold_load) begin
                hold_pc    <= pc_reg;
                hold_instr <= imem.imem_rdata;
            end
        end
    end

    // IF/ID pipeline register. A stall freezes it entirely; otherwise it
    // either takes a delivered word or turns into a bubble that keeps the
    // previous PC and instruction but drops the valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid       <= 1'b0;
            if_pc          <= 32'd0;
            if_instruction <= 32'd0;
        end else if (!id_stall) begin
            if (ifid_load) begin
                if_valid       <= 1'b1;
                if_pc          <= ifid_pc_d;
                if_instruction <= ifid_instr_d;
            end else begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_elbeth_fetch_control.sv
// Directed testbench for elbeth_fetch_control.
//
// Contains a small instruction-memory model with a programmable number of
// wait states; each word read back is a fixed scramble of its address so a
// delivered instruction identifies where it came from.
module tb_elbeth_fetch_control;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic        id_stall;
    logic        branch_taken;
    logic [31:0] pc_branch;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        if_flush;

    int checks;
    int errors;
    int mem_wait;
    int wait_cnt;

    elbeth_fetch_control_if bus ();

    elbeth_fetch_control #(
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_stall       (id_stall),
        .branch_taken   (branch_taken),
        .pc_branch      (pc_branch),
        .imem           (bus.master),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .if_flush       (if_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] addr);
        return addr ^ 32'h5A5A_0003;
    endfunction

    // Memory answers once the request has been waiting mem_wait cycles.
    always_comb begin
        bus.imem_ack   = bus.imem_req && (wait_cnt >= mem_wait);
        bus.imem_rdata = bus.imem_ack ? word_of(bus.imem_addr) : 32'hDEAD_BEEF;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= 0;
        else if (bus.imem_req && !bus.imem_ack)
            wait_cnt <= wait_cnt + 1;
        else
            wait_cnt <= 0;
    end

    task automatic set_branch(input logic [31:0] tgt);
        id_valid     = 1'b1;
        branch_taken = 1'b1;
        pc_branch    = tgt;
    endtask

    task automatic clear_branch;
        id_valid     = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_req got %b exp 0", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("[TB] FAIL rst_addr got %h exp 00000100", bus.imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got %b exp 0", if_valid); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("[TB] FAIL rst_pc got %h exp 0", if_pc); end
        checks++; if (if_instruction !== 32'h0) begin errors++; $display("[TB] FAIL rst_instr got %h exp 0", if_instruction); end
        checks++; if (if_flush !== 1'b0) begin errors++; $display("[TB] FAIL rst_flush got %b exp 0", if_flush); end
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL first_req got %b exp 1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("[TB] FAIL first_addr got %h exp 00000100", bus.imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL first_valid got %b exp 0", if_valid); end
        @(negedge clk); #1;
        checks++; if (bus.imem_addr !== 32'h104) begin errors++; $display("[TB] FAIL seq_addr104 got %h exp 00000104", bus.imem_addr); end
        checks++; if (if_valid !== 1'b1) begin errors++; $display("[TB] FAIL seq_valid got %b exp 1", if_valid); end
        checks++; if (if_pc !== 32'h100) begin errors++; $display("[TB] FAIL seq_pc100 got %h exp 00000100", if_pc); end
        checks++; if (if_instruction !== word_of(32'h100)) begin errors++; $display("[TB] FAIL seq_instr100 got %h exp %h", if_instruction, word_of(32'h100)); end
        @(negedge clk); #1;
        checks++; if (bus.imem_addr !== 32'h108) begin errors++; $display("[TB] FAIL seq_addr108 got %h exp 00000108", bus.imem_addr); end
        checks++; if (if_pc !== 32'h104) begin errors++; $display("[TB] FAIL seq_pc104 got %h exp 00000104", if_pc); end
    endtask

    task automatic test_branch;
        @(negedge clk); #1;
        checks++; if (if_pc !== 32'h108) begin errors++; $display("[TB] FAIL br_pc108 got %h exp 00000108", if_pc); end
        checks++; if (bus.imem_addr !== 32'h10C) begin errors++; $display("[TB] FAIL br_addr10c got %h exp 0000010c", bus.imem_addr); end
        set_branch(32'h200);
        #1;
        checks++; if (if_flush !== 1'b1) begin errors++; $display("[TB] FAIL br_flush got %b exp 1", if_flush); end
        @(negedge clk);
        clear_branch();
        #1;
        checks++; if (if_flush !== 1'b0) begin errors++; $display("[TB] FAIL br_flush_end got %b exp 0", if_flush); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL br_bubble got %b exp 0", if_valid); end
        checks++; if (bus.imem_addr !== 32'h200) begin errors++; $display("[TB] FAIL br_addr200 got %h exp 00000200", bus.imem_addr); end
        @(negedge clk); #1;
        checks++; if (if_valid !== 1'b1) begin errors++; $display("[TB] FAIL br_valid got %b exp 1", if_valid); end
        checks++; if (if_pc !== 32'h200) begin errors++; $display("[TB] FAIL br_pc200 got %h exp 00000200", if_pc); end
        checks++; if (if_instruction !== word_of(32'h200)) begin errors++; $display("[TB] FAIL br_instr200 got %h exp %h", if_instruction, word_of(32'h200)); end
        @(negedge clk); #1;
        checks++; if (if_pc !== 32'h204) begin errors++; $display("[TB] FAIL br_pc204 got %h exp 00000204", if_pc); end
        checks++; if (if_valid !== 1'b1) begin errors++; $display("[TB] FAIL br_valid204 got %b exp 1", if_valid); end
    endtask

    task automatic test_align_wrap;
        set_branch(32'h0000_0203);
        @(negedge clk);
        clear_branch();
        #1;
        checks++; if (bus.imem_addr !== 32'h200) begin errors++; $display("[TB] FAIL align_addr got %h exp 00000200", bus.imem_addr); end
        set_branch(32'hFFFF_FFFF);
        @(negedge clk);
        clear_branch();
        #1;
        checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_top got %h exp fffffffc", bus.imem_addr); end
        @(negedge clk); #1;
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_addr got %h exp 00000000", bus.imem_addr); end
        checks++; if (if_pc !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_pc got %h exp fffffffc", if_pc); end
        checks++; if (if_valid !== 1'b1) begin errors++; $display("[TB] FAIL wrap_valid got %b exp 1", if_valid); end
        @(negedge clk); #1;
        checks++; if (if_pc !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc0 got %h exp 00000000", if_pc); end
        checks++; if (bus.imem_addr !== 32'h4) begin errors++; $display("[TB] FAIL wrap_addr4 got %h exp 00000004", bus.imem_addr); end
    endtask

    task automatic test_wait_kill;
        set_branch(32'h20);
        @(negedge clk);
        clear_branch();
        mem_wait = 2;
        #1;
        checks++; if (bus.imem_addr !== 32'h20) begin errors++; $display("[TB] FAIL kill_addr_a got %h exp 00000020", bus.imem_addr); end
        set_branch(32'h40);
        @(negedge clk);
        clear_branch();
        #1;
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL kill_req_b got %b exp 1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h20) begin errors++; $display("[TB] FAIL kill_addr_b got %h exp 00000020", bus.imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL kill_valid_b got %b exp 0", if_valid); end
        @(negedge clk); #1;
        checks++; if (bus.imem_addr !== 32'h20) begin errors++; $display("[TB] FAIL kill_addr_c got %h exp 00000020", bus.imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL kill_valid_c got %b exp 0", if_valid); end
        @(negedge clk); #1;
        checks++; if (bus.imem_addr !== 32'h40) begin errors++; $display("[TB] FAIL kill_addr_d got %h exp 00000040", bus.imem_addr); end
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL kill_req_d got %b exp 1", bus.imem_req); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL kill_drop got %b exp 0", if_valid); end
        mem_wait = 0;
        @(negedge clk); #1;
        checks++; if (if_valid !== 1'b1) begin errors++; $display("[TB] FAIL kill_valid_e got %b exp 1", if_valid); end
        checks++; if (if_pc !== 32'h40) begin errors++; $display("[TB] FAIL kill_pc40 got %h exp 00000040", if_pc); end
        checks++; if (if_instruction !== word_of(32'h40)) begin errors++; $display("[TB] FAIL kill_instr40 got %h exp %h", if_instruction, word_of(32'h40)); end
    endtask

    task automatic test_stall;
        set_branch(32'h0C);
        @(negedge clk);
        clear_branch();
        #1;
        checks++; if (bus.imem_addr !== 32'h0C) begin errors++; $display("[TB] FAIL st_addr0c got %h exp 0000000c", bus.imem_addr); end
        @(negedge clk); #1;
        checks++; if (if_pc !== 32'h0C) begin errors++; $display("[TB] FAIL st_pc0c got %h exp 0000000c", if_pc); end
        checks++; if (bus.imem_addr !== 32'h10) begin errors++; $display("[TB] FAIL st_addr10 got %h exp 00000010", bus.imem_addr); end
        id_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 2) id_stall = 1'b0;
            #1;
            checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL st_hold_req%0d got %b exp 0", i, bus.imem_req); end
            checks++; if (if_pc !== 32'h0C || if_valid !== 1'b1) begin errors++; $display("[TB] FAIL st_hold_ifid%0d got %h/%b exp 0000000c/1", i, if_pc, if_valid); end
            checks++; if (if_instruction !== word_of(32'h0C)) begin errors++; $display("[TB] FAIL st_hold_instr%0d got %h exp %h", i, if_instruction, word_of(32'h0C)); end
        end
        @(negedge clk); #1;
        checks++; if (if_pc !== 32'h10 || if_valid !== 1'b1) begin errors++; $display("[TB] FAIL st_release got %h/%b exp 00000010/1", if_pc, if_valid); end
        checks++; if (if_instruction !== word_of(32'h10)) begin errors++; $display("[TB] FAIL st_instr10 got %h exp %h", if_instruction, word_of(32'h10)); end
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h14) begin errors++; $display("[TB] FAIL st_next_fetch got %b/%h exp 1/00000014", bus.imem_req, bus.imem_addr); end
        @(negedge clk); #1;
        checks++; if (if_pc !== 32'h14 || if_valid !== 1'b1) begin errors++; $display("[TB] FAIL st_pc14 got %h/%b exp 00000014/1", if_pc, if_valid); end
        checks++; if (bus.imem_addr !== 32'h18) begin errors++; $display("[TB] FAIL st_addr18 got %h exp 00000018", bus.imem_addr); end
    endtask

    task automatic test_reset_in_kill;
        mem_wait = 3;
        set_branch(32'h80);
        @(negedge clk);
        clear_branch();
        #1;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h18) begin errors++; $display("[TB] FAIL rk_stale got %b/%h exp 1/00000018", bus.imem_req, bus.imem_addr); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rk_req got %b exp 0", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("[TB] FAIL rk_addr got %h exp 00000100", bus.imem_addr); end
        checks++; if (if_valid !== 1'b0 || if_flush !== 1'b0) begin errors++; $display("[TB] FAIL rk_valid_flush got %b/%b exp 0/0", if_valid, if_flush); end
        checks++; if (if_pc !== 32'h0 || if_instruction !== 32'h0) begin errors++; $display("[TB] FAIL rk_ifid got %h/%h exp 0/0", if_pc, if_instruction); end
        mem_wait = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin errors++; $display("[TB] FAIL rk_restart got %b/%h exp 1/00000100", bus.imem_req, bus.imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL rk_no_stale got %b exp 0", if_valid); end
        @(negedge clk); #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin errors++; $display("[TB] FAIL rk_first got %b/%h exp 1/00000100", if_valid, if_pc); end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        mem_wait     = 0;
        rst_n        = 1'b0;
        id_valid     = 1'b0;
        id_stall     = 1'b0;
        branch_taken = 1'b0;
        pc_branch    = 32'h0;
        test_reset();
        test_branch();
        test_align_wrap();
        test_wait_kill();
        test_stall();
        test_reset_in_kill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks %0d errors %0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/elbeth_fetch_control.md
# elbeth_fetch_control

Instruction-fetch sequencer for the Elbeth RV32 core. It owns the program counter and runs the valid/ack request handshake to instruction memory. It loads the IF/ID pipeline register and redirects fetch when the ID-stage branch unit reports a taken branch or jump. It also absorbs ID-stage stalls and discards in-flight fetches made stale by a redirect.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID stage holds a valid instruction
- id_stall  in  1  hazard stall: hold the IF/ID register
- branch_taken  in  1  branch unit: redirect requested
- pc_branch  in  32  branch unit: redirect target
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address; bits [1:0] always 0
- imem_ack  in  1  memory response valid; may be asserted in the same cycle as imem_req
- imem_rdata  in  32  instruction word; valid when imem_ack=1
- if_valid  out  1  IF/ID register holds a valid instruction
- if_pc  out  32  PC of the IF/ID instruction
- if_instruction  out  32  IF/ID instruction word
- if_flush  out  1  one-cycle pulse: younger instruction squashed by a redirect

## Operation
- redirect = id_valid & branch_taken & ~id_stall. The target is {pc_branch[31:2], 2'b00}.
- Internal state:
  - pc_reg: current fetch address.
  - redirect_pc: target latched during a kill.
  - hold_buf: one-word buffer holding the instruction word and its PC.
- States:
  - BOOT: reset state. imem_req=0. Goes unconditionally to FETCH on the first clock after rst_n deasserts.
  - FETCH: imem_req=1, imem_addr=pc_reg. A request stays asserted with a stable address until ack. In FETCH, the first matching rule below applies:
    - ack & redirect: discard rdata; pc_reg<=target; stay in FETCH.
    - ack & id_stall: hold_buf<=rdata and pc_reg; pc_reg<=pc_reg+4; go to HOLD.
    - ack: IF/ID<={pc_reg, rdata, valid=1}; pc_reg<=pc_reg+4.
    - ~ack & redirect: redirect_pc<=target; go to KILL.
  - KILL: imem_req=1 with the stale address held. A further redirect overwrites redirect_pc. On ack, discard rdata, pc_reg<=redirect_pc, and go to FETCH.
  - HOLD: imem_req=0.
    - redirect: discard hold_buf, pc_reg<=target, go to FETCH. Redirect has priority over unstall.
    - ~id_stall: IF/ID<=hold_buf with valid=1; go to FETCH.
- IF/ID register:
  - id_stall=1: holds its value, except that a redirect cannot coincide with a stall.
  - redirect: if_valid<=0.
  - Not stalled and no delivery this cycle: if_valid<=0, i.e. a bubble; if_pc and if_instruction hold.
- if_flush = redirect (combinational pulse in the redirect cycle).
- PC arithmetic is modulo 2^32: 0xFFFF_FFFC+4 wraps to 0x0000_0000.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC.
  - if_valid=0, if_pc=0, if_instruction=0, if_flush=0.
  - State is BOOT; pc_reg=RESET_PC.
- rst_n assertion at any point, including mid-transaction, returns to BOOT immediately. Any outstanding response is ignored; memory must tolerate the abandoned request.
- With a zero-wait memory (ack in the request cycle), throughput is one instruction per cycle.
- The first request is issued the cycle after reset release. The first if_valid=1 follows one cycle later.
- Taken-branch penalty with zero-wait memory is one bubble:
  - Branch in ID in cycle n; target requested in cycle n+1.
  - Target visible in IF/ID in cycle n+2.
- With a wait-state memory, each extra wait cycle adds one bubble. A KILL adds the remaining wait cycles of the stale fetch.

## Test plan
- Reset release with RESET_PC=0x100 and zero-wait memory: imem_addr sequence 0x100, 0x104, 0x108. if_valid=1 from cycle 2 with if_pc=0x100.
- Taken branch at if_pc=0x108, pc_branch=0x200, zero-wait memory: if_flush pulses once. The word fetched from 0x10C is discarded. Next valid if_pc=0x200, then 0x204.
- 2-wait-state memory with a redirect to 0x40 raised while the fetch of 0x20 is outstanding: imem_addr stays 0x20 until ack, the 0x20 data is dropped, and the next request is 0x40.
- id_stall held 3 cycles while the fetch of 0x10 completes: IF/ID unchanged and imem_req=0 during HOLD. After unstall, if_pc=0x10, then a fetch of 0x14 follows. No word is lost or duplicated.
- pc_branch=0x0000_0203: imem_addr=0x200. Fetch at 0xFFFF_FFFC wraps to next imem_addr=0x0000_0000.
- rst_n pulsed low during a KILL: all outputs return to their reset values asynchronously. Fetch restarts at RESET_PC with no stale if_valid.
